fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drains the team's word FIFO from its read side and serialises each word onto a single asynchronous serial line: one start bit, DATA_W data bits LSB first, one stop bit. It drives the FIFO `pop` strobe, captures the registered `read_data` the FIFO returns one cycle later, and shifts it out at CLKS_PER_BIT clocks per bit. It is the consumer counterpart to the FIFO's push-side producer and sits between the FIFO and the chip's serial output pin.

## Interface
- DATA_W, 10, word width; must match the FIFO's DATA_W.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2.
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- tx_en  in  1  when high, the block may start new frames; when low, no new pop is issued.
- fifo_empty  in  1  FIFO occupancy is zero; driven from the FIFO's count == 0.
- read_data  in  DATA_W  FIFO output register; valid the cycle after a `pop` cycle.
- pop  out  1  one-cycle read strobe to the FIFO.
- tx  out  DATA_W?no: 1  serial line; idle level is high; registered output.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- States:
  - IDLE: tx = 1.
  - POP: pop = 1, decoded from state.
  - CAPTURE.
  - START: tx = 0.
  - DATA: tx = shift_reg[0].
  - STOP: tx = 1.
- Transitions:
  - IDLE → POP when tx_en = 1 and fifo_empty = 0, both sampled at the edge.
  - POP → CAPTURE unconditionally.
  - CAPTURE → START unconditionally; shift_reg <= read_data at this edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → STOP after DATA_W bit periods.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1.
  - Cleared on entry to START, DATA and STOP.
  - At terminal count, the bit period ends.
- Bit index:
  - Width $clog2(DATA_W); counts 0..DATA_W-1 in DATA.
  - shift_reg shifts right by one at each bit-period end.
  - DATA exits when the index reaches DATA_W-1 at terminal count.
- pop is high for exactly one cycle per frame and never in any other state. The block is the sole popper, so fifo_empty sampled low in IDLE guarantees the FIFO accepts that pop.
- tx_en low only prevents the IDLE → POP transition. A frame already in progress, from POP onward, always completes.
- fifo_empty toggling in states other than IDLE is ignored.
- A reset during a frame discards the popped word; it is not re-sent.

## Timing
- Reset values: tx = 1, pop = 0, busy = 0, frame_done = 0, state = IDLE, all counters 0.
  - Applied asynchronously on rst_n falling.
  - First transition is possible on the first rising edge after rst_n rises.
- Latency: edge k samples a non-empty FIFO in IDLE.
  - pop is high during cycle k..k+1.
  - read_data is captured at edge k+2, where tx falls to 0.
- Frame length on tx, from tx falling to the end of the stop bit: (DATA_W+2)·CLKS_PER_BIT cycles.
  - frame_done is high during the final stop-bit cycle.
  - busy falls on the edge that ends the stop bit.
- Back-to-back frames: tx stays high for CLKS_PER_BIT + 3 cycles between data frames. This is the stop bit plus the IDLE, POP and CAPTURE cycles.
  - Period per word = (DATA_W+2)·CLKS_PER_BIT + 3 cycles.
- tx is glitch-free: it changes only on clock edges and on asynchronous reset assertion.

## Test plan
All scenarios use DATA_W = 10, CLKS_PER_BIT = 4, so one frame is 48 cycles on tx.
- Reset with fifo_empty = 1 and tx_en = 1 for 100 cycles → tx = 1, pop = 0, busy = 0, frame_done = 0 throughout.
- Single word 10'h2A5, fifo_empty falls once → exactly one pop cycle.
  - tx falls 2 edges after pop rises, then stays low for 4 cycles.
  - Data bits are 1,0,1,0,0,1,0,1,0,1, each 4 cycles, LSB first.
  - Stop bit is high for 4 cycles; frame_done pulses once in the last stop cycle.
  - busy is high for 50 cycles, POP through STOP.
- Two words 10'h001 then 10'h3FF back-to-back → two pops spaced 51 cycles apart; the second start bit begins exactly 7 cycles after the first frame's last data bit ends.
- tx_en dropped during DATA of frame 1 while fifo_empty = 0 → frame 1 completes fully, no further pop, tx stays 1. Raising tx_en later → pop on the next edge.
- Reset asserted during data bit 5 → tx = 1, busy = 0, pop = 0 immediately (asynchronously). After release with fifo_empty = 0 → a new pop, and the next word is transmitted in full.
- Integration with the FIFO instance: push 3 words 10'h0AA, 10'h155, 10'h3C3 → all three are transmitted in order with 3 pops total, and pop is never asserted while the FIFO count is 0.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Read-side consumer for the team word FIFO. Pops one word at a time and
// serialises it onto an asynchronous serial line: one start bit (low),
// DATA_W data bits LSB first, one stop bit (high), CLKS_PER_BIT clocks per
// bit. The FIFO's read_data register is valid the cycle after pop, so a
// CAPTURE state sits between POP and START to pick it up.
//
// Parameters
//   DATA_W        word width, must match the FIFO
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports
//   clock       system clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_en       permits new frames to start (in-flight frames always finish)
//   fifo_empty  FIFO occupancy is zero
//   read_data   FIFO output register, valid the cycle after pop
//   pop         one-cycle read strobe to the FIFO
//   tx          registered serial output, idle high
//   busy        high in every state except IDLE
//   frame_done  one-cycle pulse during the last cycle of the stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] read_data,
  output logic              pop,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_CAPTURE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state, state_nx;
  logic [BAUD_W-1:0]   baud, baud_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [DATA_W-1:0]   shift_reg, shift_nx;
  logic                tx_nx;
  logic                bit_end;

  // Terminal count of the baud counter ends the current bit period.
  assign bit_end = (baud == BAUD_LAST);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      baud      <= '0;
      idx       <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nx;
      baud      <= baud_nx;
      idx       <= idx_nx;
      shift_reg <= shift_nx;
      tx        <= tx_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    idx_nx   = idx;
    shift_nx = shift_reg;

    case (state)
      S_IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_nx = S_POP;
        end
      end

      S_POP: begin
        state_nx = S_CAPTURE;
      end

      S_CAPTURE: begin
        state_nx = S_START;
        shift_nx = read_data;
        baud_nx  = '0;
      end

      S_START: begin
        if (bit_end) begin
          state_nx = S_DATA;
          baud_nx  = '0;
          idx_nx   = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_nx  = '0;
          shift_nx = shift_reg >> 1;
          if (idx == IDX_LAST) begin
            state_nx = S_STOP;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else begin
          baud_nx = baud + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          state_nx = S_IDLE;
          baud_nx  = '0;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end

      default: begin
        state_nx = S_IDLE;
        baud_nx  = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // tx is registered from the next state so the line level lands on the
  // same edge as the state change (tx falls on the CAPTURE->START edge).
  // On DATA entry shift_nx still holds the unshifted word, so bit 0 goes
  // out first.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      S_START: tx_nx = 1'b0;
      S_DATA:  tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs
  // -------------------------------------------------------------------------
  assign pop        = (state == S_POP);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Bench for fifo_uart_tx with DATA_W = 10, CLKS_PER_BIT = 4. A small
// behavioural FIFO with a registered read port feeds the DUT; every word
// pushed into it is also appended to an expected-word queue. A serial
// monitor decodes tx frame by frame and compares each word with the queue
// head. Frame timing, pop behaviour, tx_en gating and mid-frame reset are
// checked around that.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int unsigned DW    = 10;
  localparam int unsigned CPB   = 4;
  localparam int          FRAME = (DW + 2) * CPB;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_en = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] read_data = '0;
  logic          pop;
  logic          tx;
  logic          busy;
  logic          frame_done;

  fifo_uart_tx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .read_data  (read_data),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // -------------------------------------------------------------------------
  // Checker
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural FIFO (not affected by the DUT reset) plus expected queue
  // -------------------------------------------------------------------------
  logic [DW-1:0] fifo_mem [16];
  int            fifo_wr  = 0;
  int            fifo_rd  = 0;
  int            fifo_cnt = 0;
  logic          push_valid = 1'b0;
  logic [DW-1:0] push_data  = '0;
  int            cyc = 0;
  logic [DW-1:0] exp_q [$];

  assign fifo_empty = (fifo_cnt == 0);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (pop && fifo_cnt != 0) begin
      read_data <= fifo_mem[fifo_rd[3:0]];
      fifo_rd   <= fifo_rd + 1;
    end
    if (push_valid) begin
      fifo_mem[fifo_wr[3:0]] <= push_data;
      fifo_wr <= fifo_wr + 1;
      exp_q.push_back(push_data);
    end
    fifo_cnt <= fifo_cnt + (push_valid ? 1 : 0) - ((pop && fifo_cnt != 0) ? 1 : 0);
  end

  task automatic push_word(input logic [DW-1:0] w);
    push_valid = 1'b1;
    push_data  = w;
    @(posedge clock);
    #1 push_valid = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Serial monitor / scoreboard consumer, sampling on the falling edge
  // -------------------------------------------------------------------------
  bit            mon_active  = 1'b0;
  int            mcnt        = 0;
  int            mpos        = 0;
  int            msub        = 0;
  logic          prev_tx     = 1'b1;
  logic          prev_pop    = 1'b0;
  logic [DW-1:0] rx          = '0;
  int            exp_rd      = 0;
  int            frames_done = 0;
  int            pop_total   = 0;
  int            busy_cnt    = 0;
  int            fd_total    = 0;
  int            pop_cyc_q [$];
  int            start_q   [$];

  always @(negedge clock) begin
    if (!rst_n) begin
      // Frame cut short by reset: its word is discarded, never re-sent.
      if (mon_active) begin
        mon_active = 1'b0;
        exp_rd++;
      end
      prev_tx  = 1'b1;
      prev_pop = 1'b0;
    end else begin
      if (pop) begin
        pop_total++;
        pop_cyc_q.push_back(cyc);
        check("pop_nonempty", (fifo_cnt != 0), 1);
        check("pop_single", prev_pop, 0);
      end
      prev_pop = pop;
      if (busy)       busy_cnt++;
      if (frame_done) fd_total++;

      if (!mon_active && prev_tx && !tx) begin
        mon_active = 1'b1;
        mcnt       = 0;
        start_q.push_back(cyc);
      end

      if (mon_active) begin
        mpos = mcnt / CPB;
        msub = mcnt % CPB;
        if (mpos == 0) begin
          if (msub != 0) check("start_bit", tx, 0);
        end else if (mpos <= DW) begin
          if (msub == 0) rx[mpos-1] = tx;
          else           check("bit_hold", tx, rx[mpos-1]);
        end else begin
          check("stop_bit", tx, 1);
          check("frame_done", frame_done, (msub == CPB - 1));
        end
        if (mcnt == FRAME - 1) begin
          if (exp_rd < exp_q.size()) check("word", rx, exp_q[exp_rd]);
          else                       check("sb_underrun", exp_q.size(), exp_rd + 1);
          exp_rd++;
          frames_done++;
          mon_active = 1'b0;
        end
        mcnt++;
      end
      prev_tx = tx;
    end
  end

  // Waits until the given number of frames have completed and the DUT is idle.
  task automatic wait_frames(input int target, input int limit);
    int n;
    n = 0;
    while ((frames_done < target || busy) && n < limit) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("wait_frames_timeout", (n < limit), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int p0, b0, fd0, fr, n;

    // Reset, then a long idle stretch with an empty FIFO and tx_en high.
    rst_n = 1'b0;
    tx_en = 1'b1;
    repeat (5) @(negedge clock);
    check("rst_outs", {tx, pop, busy, frame_done}, 4'b1000);
    #1 rst_n = 1'b1;
    repeat (100) begin
      @(negedge clock);
      check("idle_outs", {tx, pop, busy, frame_done}, 4'b1000);
    end

    // Single word.
    #1;
    p0 = pop_total; b0 = busy_cnt; fd0 = fd_total; fr = frames_done;
    push_word(10'h2A5);
    wait_frames(fr + 1, 200);
    check("single_pops", pop_total - p0, 1);
    check("pop_to_start", start_q[$] - pop_cyc_q[$], 2);
    check("busy_cycles", busy_cnt - b0, 50);
    check("frame_done_pulses", fd_total - fd0, 1);

    // Back-to-back words.
    p0 = pop_total; fr = frames_done;
    push_word(10'h001);
    push_word(10'h3FF);
    wait_frames(fr + 2, 300);
    check("b2b_pops", pop_total - p0, 2);
    check("b2b_pop_spacing", pop_cyc_q[$] - pop_cyc_q[$-1], 51);
    check("b2b_start_spacing", start_q[$] - start_q[$-1], 51);

    // tx_en dropped in the middle of a frame while more data is waiting.
    p0 = pop_total; fr = frames_done;
    push_word(10'h0F0);
    push_word(10'h30C);
    n = 0;
    while (!(mon_active && mcnt >= 3 * CPB) && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("reach_data", (n < 200), 1);
    tx_en = 1'b0;
    wait_frames(fr + 1, 200);
    repeat (60) begin
      @(negedge clock);
      check("hold_idle", {pop, tx, busy}, 3'b010);
    end
    check("txen_pops", pop_total - p0, 1);
    #1 tx_en = 1'b1;
    @(negedge clock);
    check("resume_pop", pop, 1);
    #1;
    wait_frames(fr + 2, 200);
    check("txen_total_pops", pop_total - p0, 2);

    // Reset during data bit 5 (a 0 bit of 10'h1D5).
    fr = frames_done;
    push_word(10'h1D5);
    push_word(10'h16C);
    n = 0;
    while (!(mon_active && mcnt >= 6 * CPB + 2) && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("reach_bit5", (n < 200), 1);
    check("bit5_low", {tx, busy}, 2'b01);
    #2 rst_n = 1'b0;
    #1 check("async_rst", {tx, busy, pop}, 3'b100);
    p0 = pop_total;
    repeat (3) @(negedge clock);
    #1 rst_n = 1'b1;
    wait_frames(fr + 1, 200);
    check("post_rst_pops", pop_total - p0, 1);
    check("post_rst_drained", exp_rd, exp_q.size());

    // Three words through the FIFO in order.
    p0 = pop_total; fr = frames_done;
    push_word(10'h0AA);
    push_word(10'h155);
    push_word(10'h3C3);
    wait_frames(fr + 3, 400);
    check("integ_pops", pop_total - p0, 3);
    check("integ_frames", frames_done - fr, 3);
    check("sb_drained", exp_rd, exp_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
